// File: rtl/tour_pred_pkg.sv
// Shared constants, types and saturating-counter helpers for the tournament predictor.
package tour_pred_pkg;

  localparam int unsigned LHT_IDX_BITS_DEF = 10;
  localparam int unsigned LHIST_BITS_DEF   = 4;
  localparam int unsigned GHIST_BITS_DEF   = 8;
  localparam int unsigned CNT_BITS_DEF     = 2;

  // Helpers work on a fixed wide type; callers cast back to their counter width.
  localparam int unsigned CNT_WIDE_BITS = 16;
  typedef logic [CNT_WIDE_BITS-1:0] cnt_wide_t;

  typedef enum logic {
    SEL_LOCAL  = 1'b0,
    SEL_GLOBAL = 1'b1
  } comp_sel_e;

  function automatic cnt_wide_t cnt_ones(input int unsigned w);
    cnt_wide_t v;
    v = '0;
    for (int unsigned i = 0; i < w; i++) v[i] = 1'b1;
    return v;
  endfunction

  // Weakly not-taken / weakly local: 2^(w-1)-1.
  function automatic cnt_wide_t CNT_INIT(input int unsigned w);
    return cnt_ones(w - 1);
  endfunction

  function automatic cnt_wide_t sat_inc(input cnt_wide_t v, input int unsigned w);
    return (v == cnt_ones(w)) ? v : v + cnt_wide_t'(1);
  endfunction

  function automatic cnt_wide_t sat_dec(input cnt_wide_t v);
    return (v == '0) ? v : v - cnt_wide_t'(1);
  endfunction

endpackage

// File: rtl/sat_cnt_table.sv
// Table of saturating counters: one combinational read port, one registered
// increment/decrement port, asynchronous reset to CNT_INIT.
module sat_cnt_table
  import tour_pred_pkg::*;
#(
  parameter int unsigned IDX_BITS = GHIST_BITS_DEF,
  parameter int unsigned CNT_BITS = CNT_BITS_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [IDX_BITS-1:0] rd_idx_i,
  output logic [CNT_BITS-1:0] rd_cnt_o,
  input  logic                upd_en_i,
  input  logic [IDX_BITS-1:0] upd_idx_i,
  input  logic                upd_inc_i
);

  localparam int unsigned DEPTH = 2 ** IDX_BITS;
  localparam logic [CNT_BITS-1:0] INIT = CNT_BITS'(CNT_INIT(CNT_BITS));

  logic [CNT_BITS-1:0] cnt_q [DEPTH];
  logic [CNT_BITS-1:0] upd_cnt_d;

  // No bypass: a same-cycle read sees the pre-update value.
  assign rd_cnt_o = cnt_q[rd_idx_i];

  always_comb begin
    upd_cnt_d = cnt_q[upd_idx_i];
    if (upd_inc_i) begin
      upd_cnt_d = CNT_BITS'(sat_inc(cnt_wide_t'(cnt_q[upd_idx_i]), CNT_BITS));
    end else begin
      upd_cnt_d = CNT_BITS'(sat_dec(cnt_wide_t'(cnt_q[upd_idx_i])));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) cnt_q[i] <= INIT;
    end else if (upd_en_i) begin
      cnt_q[upd_idx_i] <= upd_cnt_d;
    end
  end

endmodule

// File: rtl/tour_pred_param.sv
// Parametrised tournament (local/global/chooser) branch predictor with speculative GHR
// and checkpoint repair. Define TOUR_PRED_GSHARE_EN to XOR PC bits into the global index.
module tour_pred_param
  import tour_pred_pkg::*;
#(
  parameter int unsigned LHT_IDX_BITS = LHT_IDX_BITS_DEF,
  parameter int unsigned LHIST_BITS   = LHIST_BITS_DEF,
  parameter int unsigned GHIST_BITS   = GHIST_BITS_DEF,
  parameter int unsigned CNT_BITS     = CNT_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           pc_d,
  input  logic                  branch_d,
  input  logic                  stall_d,
  output logic                  pred_take_d,
  output logic                  pred_loc_d,
  output logic                  pred_glo_d,
  output logic [GHIST_BITS-1:0] ghist_d,
  input  logic                  upd_valid_m,
  input  logic [31:0]           upd_pc_m,
  input  logic                  upd_taken_m,
  input  logic                  upd_pred_m,
  input  logic                  upd_loc_m,
  input  logic                  upd_glo_m,
  input  logic [GHIST_BITS-1:0] upd_ghist_m,
  output logic                  pred_wrong_m
);

  localparam int unsigned LHT_DEPTH = 2 ** LHT_IDX_BITS;

  logic [LHIST_BITS-1:0]   lht_q [LHT_DEPTH];
  logic [LHIST_BITS-1:0]   lht_upd_d;
  logic [GHIST_BITS-1:0]   ghr_q, ghr_d;

  logic [LHT_IDX_BITS-1:0] lht_rd_idx, lht_upd_idx;
  logic [LHIST_BITS-1:0]   lpht_rd_idx, lpht_upd_idx;
  logic [GHIST_BITS-1:0]   gidx_rd, gidx_upd;
  logic [CNT_BITS-1:0]     loc_cnt, glo_cnt, cho_cnt;
  comp_sel_e               sel;
  logic                    cho_en, cho_inc;
  logic                    unused_pc;

  assign lht_rd_idx   = pc_d[LHT_IDX_BITS+1:2];
  assign lht_upd_idx  = upd_pc_m[LHT_IDX_BITS+1:2];
  assign lpht_rd_idx  = lht_q[lht_rd_idx];
  assign lpht_upd_idx = lht_q[lht_upd_idx];

`ifdef TOUR_PRED_GSHARE_EN
  assign gidx_rd  = ghr_q ^ pc_d[GHIST_BITS+1:2];
  assign gidx_upd = upd_ghist_m ^ upd_pc_m[GHIST_BITS+1:2];
`else
  assign gidx_rd  = ghr_q;
  assign gidx_upd = upd_ghist_m;
`endif

  assign unused_pc = ^{pc_d[31:LHT_IDX_BITS+2], pc_d[1:0],
                       upd_pc_m[31:LHT_IDX_BITS+2], upd_pc_m[1:0]};

  // Chooser moves only on disagreement: toward global if global was right.
  assign cho_en  = upd_valid_m & (upd_loc_m != upd_glo_m);
  assign cho_inc = (upd_glo_m == upd_taken_m);

  sat_cnt_table #(.IDX_BITS(LHIST_BITS), .CNT_BITS(CNT_BITS)) u_loc_pht (
    .clk_i     (clk),
    .rst_i     (rst),
    .rd_idx_i  (lpht_rd_idx),
    .rd_cnt_o  (loc_cnt),
    .upd_en_i  (upd_valid_m),
    .upd_idx_i (lpht_upd_idx),
    .upd_inc_i (upd_taken_m)
  );

  sat_cnt_table #(.IDX_BITS(GHIST_BITS), .CNT_BITS(CNT_BITS)) u_glo_pht (
    .clk_i     (clk),
    .rst_i     (rst),
    .rd_idx_i  (gidx_rd),
    .rd_cnt_o  (glo_cnt),
    .upd_en_i  (upd_valid_m),
    .upd_idx_i (gidx_upd),
    .upd_inc_i (upd_taken_m)
  );

  sat_cnt_table #(.IDX_BITS(GHIST_BITS), .CNT_BITS(CNT_BITS)) u_chooser (
    .clk_i     (clk),
    .rst_i     (rst),
    .rd_idx_i  (gidx_rd),
    .rd_cnt_o  (cho_cnt),
    .upd_en_i  (cho_en),
    .upd_idx_i (gidx_upd),
    .upd_inc_i (cho_inc)
  );

  assign pred_loc_d   = loc_cnt[CNT_BITS-1];
  assign pred_glo_d   = glo_cnt[CNT_BITS-1];
  assign sel          = comp_sel_e'(cho_cnt[CNT_BITS-1]);
  assign pred_take_d  = branch_d & ((sel == SEL_GLOBAL) ? pred_glo_d : pred_loc_d);
  assign ghist_d      = ghr_q;
  assign pred_wrong_m = upd_valid_m & (upd_pred_m != upd_taken_m);

  // Repair from the Memory checkpoint overrides any Decode speculation this cycle.
  always_comb begin
    ghr_d = ghr_q;
    if (pred_wrong_m) begin
      ghr_d = {upd_ghist_m[GHIST_BITS-2:0], upd_taken_m};
    end else if (branch_d && !stall_d) begin
      ghr_d = {ghr_q[GHIST_BITS-2:0], pred_take_d};
    end
  end

  always_comb begin
    lht_upd_d = {lht_q[lht_upd_idx][LHIST_BITS-2:0], upd_taken_m};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < LHT_DEPTH; i++) lht_q[i] <= '0;
    end else if (upd_valid_m) begin
      lht_q[lht_upd_idx] <= lht_upd_d;
    end
  end

endmodule

// File: tb/tb_tour_pred_param.sv
// Scoreboard bench for tour_pred_param: directed stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares them against the outputs.
module tb_tour_pred_param;

  localparam int unsigned GH = 8;
`ifdef TOUR_PRED_GSHARE_EN
  localparam logic GS = 1'b1;
`else
  localparam logic GS = 1'b0;
`endif

  localparam logic [4:0] M_TAKE = 5'b00001;
  localparam logic [4:0] M_LOC  = 5'b00010;
  localparam logic [4:0] M_GLO  = 5'b00100;
  localparam logic [4:0] M_GH   = 5'b01000;
  localparam logic [4:0] M_WR   = 5'b10000;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   pc_d;
  logic          branch_d, stall_d;
  logic          pred_take_d, pred_loc_d, pred_glo_d;
  logic [GH-1:0] ghist_d;
  logic          upd_valid_m;
  logic [31:0]   upd_pc_m;
  logic          upd_taken_m, upd_pred_m, upd_loc_m, upd_glo_m;
  logic [GH-1:0] upd_ghist_m;
  logic          pred_wrong_m;

  typedef struct {
    string      name;
    logic [4:0] mask;
    logic       take;
    logic       loc;
    logic       glo;
    logic [7:0] gh;
    logic       wrong;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  tour_pred_param #(
    .LHT_IDX_BITS(10),
    .LHIST_BITS  (4),
    .GHIST_BITS  (GH),
    .CNT_BITS    (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_d        (pc_d),
    .branch_d    (branch_d),
    .stall_d     (stall_d),
    .pred_take_d (pred_take_d),
    .pred_loc_d  (pred_loc_d),
    .pred_glo_d  (pred_glo_d),
    .ghist_d     (ghist_d),
    .upd_valid_m (upd_valid_m),
    .upd_pc_m    (upd_pc_m),
    .upd_taken_m (upd_taken_m),
    .upd_pred_m  (upd_pred_m),
    .upd_loc_m   (upd_loc_m),
    .upd_glo_m   (upd_glo_m),
    .upd_ghist_m (upd_ghist_m),
    .pred_wrong_m(pred_wrong_m)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input string f, input logic [7:0] got, input logic [7:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s %s: got %h expected %h", n, f, got, want);
    end
  endtask

  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      if (mon_e.mask[0]) chk(mon_e.name, "pred_take_d", {7'd0, pred_take_d}, {7'd0, mon_e.take});
      if (mon_e.mask[1]) chk(mon_e.name, "pred_loc_d", {7'd0, pred_loc_d}, {7'd0, mon_e.loc});
      if (mon_e.mask[2]) chk(mon_e.name, "pred_glo_d", {7'd0, pred_glo_d}, {7'd0, mon_e.glo});
      if (mon_e.mask[3]) chk(mon_e.name, "ghist_d", ghist_d, mon_e.gh);
      if (mon_e.mask[4]) chk(mon_e.name, "pred_wrong_m", {7'd0, pred_wrong_m}, {7'd0, mon_e.wrong});
    end
  end

  task automatic expect_out(input string n, input logic [4:0] m, input logic t, input logic l,
                            input logic g, input logic [7:0] h, input logic w);
    exp_t e;
    e.name = n; e.mask = m; e.take = t; e.loc = l; e.glo = g; e.gh = h; e.wrong = w;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pc_d = '0; branch_d = 1'b0; stall_d = 1'b0;
    upd_valid_m = 1'b0; upd_pc_m = '0; upd_taken_m = 1'b0; upd_pred_m = 1'b0;
    upd_loc_m = 1'b0; upd_glo_m = 1'b0; upd_ghist_m = '0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic pr, input logic lo,
                     input logic gl, input logic [7:0] gh);
    upd_valid_m = 1'b1; upd_pc_m = pc; upd_taken_m = tk; upd_pred_m = pr;
    upd_loc_m = lo; upd_glo_m = gl; upd_ghist_m = gh;
  endtask

  task automatic query(input logic [31:0] pc, input logic st);
    branch_d = 1'b1; pc_d = pc; stall_d = st;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic o, le, ge;
  logic [31:0] g2 [10];
  logic [1:0]  s2 [10];

  initial begin
    idle();
    rst = 1'b1;
    #12;
    rst = 1'b0;
    tick();

    // Reset state
    query(32'h0000_1234, 1'b1);
    expect_out("reset", M_TAKE | M_LOC | M_GLO | M_GH | M_WR, 0, 0, 0, 8'h00, 0);
    tick();

    // Global counter saturation at PC 0x40, GHR frozen at 0
    do_reset();
    // per cycle: {valid, taken} and expected glo before the update
    s2 = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b00};
    g2 = '{0, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    for (int i = 0; i < 10; i++) begin
      idle();
      query(32'h40, 1'b1);
      if (s2[i][1]) upd(32'h40, s2[i][0], s2[i][0], 1'b0, 1'b0, 8'h00);
      expect_out($sformatf("sat_c%0d", i), M_GLO | M_GH | M_WR, 0, 0, g2[i][0], 8'h00, 0);
      tick();
    end

    // Alternating pattern at PC 0x80: local learns it, global always errs
    do_reset();
    for (int k = 0; k < 20; k++) begin
      o  = (k % 2 == 0);
      le = (k >= 5) ? o : 1'b0;
      ge = (k % 2 == 1);
      idle();
      query(32'h80, 1'b1);
      upd(32'h80, o, o, le, ge, 8'h00);
      expect_out($sformatf("alt_k%0d", k), M_TAKE | M_LOC | M_GLO | M_WR, le, le, ge, 8'h00, 0);
      tick();
    end

    // Speculative GHR shift and repair; local trained taken at PC 0x100
    do_reset();
    for (int i = 0; i < 6; i++) begin
      idle();
      upd(32'h100, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
      expect_out("train100", M_GH | M_WR, 0, 0, 0, 8'h00, 0);
      tick();
    end
    g2 = '{32'h00, 32'h01, 32'h03, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 3; i++) begin
      idle();
      query(32'h100, 1'b0);
      expect_out($sformatf("spec_%0d", i), M_TAKE | M_LOC | M_GH, 1, 1, 0, g2[i][7:0], 0);
      tick();
    end
    idle();
    query(32'h100, 1'b0);
    upd(32'h200, 1'b0, 1'b1, 1'b1, 1'b1, 8'h03);
    expect_out("repair_cyc", M_TAKE | M_GH | M_WR, 1, 0, 0, 8'h07, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      idle();
      query(32'h100, 1'b1);
      expect_out($sformatf("stall_%0d", i), M_TAKE | M_GH | M_WR, 1, 0, 0, 8'h06, 0);
      tick();
    end
    idle();
    query(32'h100, 1'b1);
    upd(32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    expect_out("rw_same", M_LOC | M_GH | M_WR, 0, 1, 0, 8'h06, 0);
    tick();
    idle();
    query(32'h100, 1'b1);
    expect_out("rw_next", M_TAKE | M_LOC | M_GH, 0, 0, 0, 8'h06, 0);
    tick();

    // Asynchronous reset mid-operation, sampled before any clock edge
    idle();
    query(32'h100, 1'b1);
    rst = 1'b1;
    expect_out("async_rst", M_TAKE | M_LOC | M_GLO | M_GH, 0, 0, 0, 8'h00, 0);
    tick();
    rst = 1'b0;

    // Global index selection: with gshare, GHR=0x05 ^ pc 0x0C hits 0x06
    do_reset();
    for (int i = 0; i < 2; i++) begin
      idle();
      upd(32'h0C, 1'b1, 1'b1, 1'b0, 1'b0, 8'h05);
      expect_out("gidx_train", M_GH | M_WR, 0, 0, 0, 8'h00, 0);
      tick();
    end
    idle();
    upd(32'h3F0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h02);
    expect_out("gidx_repair", M_GH | M_WR, 0, 0, 0, 8'h00, 1);
    tick();
    idle();
    query(32'h0C, 1'b1);
    expect_out("gidx_pc0c", M_GLO | M_GH | M_WR, 0, 0, 1, 8'h05, 0);
    tick();
    idle();
    query(32'h00, 1'b1);
    expect_out("gidx_pc00", M_GLO | M_GH, 0, 0, ~GS, 8'h05, 0);
    tick();

    idle();
    for (int i = 0; i < 4 && sb_q.size() > 0; i++) tick();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
